// File: rtl/unified_cache_mem_scheduler.sv
// Shares one memory request/response port between NUM_BANK cache banks, tracking misses in order.
// Optional macro UNIFIED_CACHE_MEM_CRITICAL_FIRST_EN enables critical-first arbitration levels.
`ifndef UNIFIED_CACHE_PACKET_WIDTH_IN_BITS
`define UNIFIED_CACHE_PACKET_WIDTH_IN_BITS 32
`endif

module unified_cache_mem_scheduler #(
    parameter int NUM_BANK                           = 4,
    parameter int UNIFIED_CACHE_PACKET_WIDTH_IN_BITS = `UNIFIED_CACHE_PACKET_WIDTH_IN_BITS,
    parameter int MAX_OUTSTANDING                    = 4
) (
    input  logic                                                clk_in,
    input  logic                                                reset_in,
    input  logic [NUM_BANK*UNIFIED_CACHE_PACKET_WIDTH_IN_BITS-1:0] bank_miss_request_flatted_in,
    input  logic [NUM_BANK-1:0]                                 bank_miss_request_valid_flatted_in,
    input  logic [NUM_BANK-1:0]                                 bank_miss_request_critical_flatted_in,
    output logic [NUM_BANK-1:0]                                 bank_miss_request_ack_out,
    input  logic [NUM_BANK*UNIFIED_CACHE_PACKET_WIDTH_IN_BITS-1:0] bank_writeback_request_flatted_in,
    input  logic [NUM_BANK-1:0]                                 bank_writeback_request_valid_flatted_in,
    input  logic [NUM_BANK-1:0]                                 bank_writeback_request_critical_flatted_in,
    output logic [NUM_BANK-1:0]                                 bank_writeback_request_ack_out,
    output logic [UNIFIED_CACHE_PACKET_WIDTH_IN_BITS-1:0]       mem_request_out,
    output logic                                                mem_request_valid_out,
    output logic                                                mem_request_is_write_out,
    input  logic                                                mem_request_ack_in,
    input  logic [UNIFIED_CACHE_PACKET_WIDTH_IN_BITS-1:0]       mem_response_in,
    input  logic                                                mem_response_valid_in,
    output logic                                                mem_response_ack_out,
    output logic [UNIFIED_CACHE_PACKET_WIDTH_IN_BITS-1:0]       bank_fetched_request_out,
    output logic [NUM_BANK-1:0]                                 bank_fetched_request_valid_flatted_out,
    input  logic [NUM_BANK-1:0]                                 bank_fetch_ack_flatted_in,
    output logic [$clog2(MAX_OUTSTANDING):0]                    outstanding_count_out,
    output logic                                                unexpected_response_out
);
    localparam int W     = UNIFIED_CACHE_PACKET_WIDTH_IN_BITS;
    localparam int BID_W = $clog2(NUM_BANK);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    logic             req_vld_p0, req_wr_p0;
    logic [W-1:0]     req_pkt_p0;
    logic [BID_W-1:0] wb_ptr, miss_ptr;
    logic [BID_W-1:0] fifo_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [CNT_W-1:0] count;
    logic             unexpected;

    logic             fifo_empty, resp_pop, miss_ok, load_ok;
    logic [BID_W-1:0] head;
    logic [NUM_BANK-1:0] miss_req;
    logic             grant_wb, grant_miss;
    logic [BID_W-1:0] grant_bank;
    logic [W-1:0]     grant_pkt;

    // Returns {found, bank}: first requester at or after ptr, wrapping.
    function automatic logic [BID_W:0] rr_pick(input logic [NUM_BANK-1:0] req,
                                               input logic [BID_W-1:0] ptr);
        logic [BID_W:0]   res;
        logic [BID_W-1:0] idx;
        res = '0;
        for (int i = NUM_BANK - 1; i >= 0; i--) begin
            idx = ptr + BID_W'(i);
            if (req[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    assign head       = fifo_mem[rd_ptr];
    assign fifo_empty = (count == '0);
    assign resp_pop   = !reset_in && mem_response_valid_in && !fifo_empty
                        && bank_fetch_ack_flatted_in[head];
    // A pop in this cycle frees a slot, so a miss may be granted even when full.
    assign miss_ok    = (count != CNT_W'(MAX_OUTSTANDING)) || resp_pop;
    assign load_ok    = !reset_in && (!req_vld_p0 || mem_request_ack_in);
    assign miss_req   = bank_miss_request_valid_flatted_in & {NUM_BANK{miss_ok}};

`ifdef UNIFIED_CACHE_MEM_CRITICAL_FIRST_EN
    always_comb begin
        logic [BID_W:0] p_cw, p_cm, p_nw, p_nm;
        p_cw = rr_pick(bank_writeback_request_valid_flatted_in
                       & bank_writeback_request_critical_flatted_in, wb_ptr);
        p_cm = rr_pick(miss_req & bank_miss_request_critical_flatted_in, miss_ptr);
        p_nw = rr_pick(bank_writeback_request_valid_flatted_in
                       & ~bank_writeback_request_critical_flatted_in, wb_ptr);
        p_nm = rr_pick(miss_req & ~bank_miss_request_critical_flatted_in, miss_ptr);
        grant_wb   = 1'b0;
        grant_miss = 1'b0;
        grant_bank = '0;
        if (load_ok) begin
            if (p_cw[BID_W]) begin
                grant_wb = 1'b1; grant_bank = p_cw[BID_W-1:0];
            end else if (p_cm[BID_W]) begin
                grant_miss = 1'b1; grant_bank = p_cm[BID_W-1:0];
            end else if (p_nw[BID_W]) begin
                grant_wb = 1'b1; grant_bank = p_nw[BID_W-1:0];
            end else if (p_nm[BID_W]) begin
                grant_miss = 1'b1; grant_bank = p_nm[BID_W-1:0];
            end
        end
    end
`else
    logic unused_critical;
    assign unused_critical = ^{bank_miss_request_critical_flatted_in,
                               bank_writeback_request_critical_flatted_in};

    always_comb begin
        logic [BID_W:0] p_w, p_m;
        p_w = rr_pick(bank_writeback_request_valid_flatted_in, wb_ptr);
        p_m = rr_pick(miss_req, miss_ptr);
        grant_wb   = 1'b0;
        grant_miss = 1'b0;
        grant_bank = '0;
        if (load_ok) begin
            if (p_w[BID_W]) begin
                grant_wb = 1'b1; grant_bank = p_w[BID_W-1:0];
            end else if (p_m[BID_W]) begin
                grant_miss = 1'b1; grant_bank = p_m[BID_W-1:0];
            end
        end
    end
`endif

    assign grant_pkt = grant_wb ? bank_writeback_request_flatted_in[grant_bank*W +: W]
                                : bank_miss_request_flatted_in[grant_bank*W +: W];

    always_comb begin
        for (int i = 0; i < NUM_BANK; i++) begin
            bank_writeback_request_ack_out[i]         = grant_wb && (grant_bank == BID_W'(i));
            bank_miss_request_ack_out[i]              = grant_miss && (grant_bank == BID_W'(i));
            bank_fetched_request_valid_flatted_out[i] = !reset_in && mem_response_valid_in
                                                        && !fifo_empty && (head == BID_W'(i));
        end
    end

    // Responses with nothing in flight are swallowed immediately.
    assign mem_response_ack_out     = !reset_in && mem_response_valid_in
                                      && (fifo_empty || bank_fetch_ack_flatted_in[head]);
    assign bank_fetched_request_out = mem_response_in;

    // Stage p0: output request register, arbitration pointers, miss tracking.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            req_vld_p0 <= 1'b0;
            req_wr_p0  <= 1'b0;
            req_pkt_p0 <= '0;
            wb_ptr     <= '0;
            miss_ptr   <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            unexpected <= 1'b0;
        end else begin
            if (grant_wb || grant_miss) begin
                req_vld_p0 <= 1'b1;
                req_wr_p0  <= grant_wb;
                req_pkt_p0 <= grant_pkt;
            end else if (mem_request_ack_in) begin
                req_vld_p0 <= 1'b0;
            end
            if (grant_wb)   wb_ptr   <= grant_bank + 1'b1;
            if (grant_miss) miss_ptr <= grant_bank + 1'b1;
            if (grant_miss) wr_ptr   <= wr_ptr + 1'b1;
            if (resp_pop)   rd_ptr   <= rd_ptr + 1'b1;
            if (grant_miss && !resp_pop)      count <= count + 1'b1;
            else if (!grant_miss && resp_pop) count <= count - 1'b1;
            if (mem_response_valid_in && fifo_empty) unexpected <= 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (grant_miss) fifo_mem[wr_ptr] <= grant_bank;
    end

    assign mem_request_out          = req_pkt_p0;
    assign mem_request_valid_out    = req_vld_p0;
    assign mem_request_is_write_out = req_wr_p0;
    assign outstanding_count_out    = count;
    assign unexpected_response_out  = unexpected;

endmodule

// File: tb/tb_unified_cache_mem_scheduler.sv
// Scoreboard bench for unified_cache_mem_scheduler: request transfers are checked against a queue.
`ifndef UNIFIED_CACHE_PACKET_WIDTH_IN_BITS
`define UNIFIED_CACHE_PACKET_WIDTH_IN_BITS 32
`endif

module tb_unified_cache_mem_scheduler;
    localparam int NB = 4;
    localparam int W  = 32;
    localparam int MO = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [NB*W-1:0] miss_pkt, wb_pkt;
    logic [NB-1:0]   miss_valid, miss_crit, miss_ack;
    logic [NB-1:0]   wb_valid, wb_crit, wb_ack;
    logic [W-1:0]    mem_pkt;
    logic            mem_valid, mem_wr, mem_ack;
    logic [W-1:0]    resp_pkt;
    logic            resp_valid, resp_ack;
    logic [W-1:0]    fetched_pkt;
    logic [NB-1:0]   fetched_valid, fetch_ack;
    logic [$clog2(MO):0] count;
    logic            unexpected;

    unified_cache_mem_scheduler #(
        .NUM_BANK(NB), .UNIFIED_CACHE_PACKET_WIDTH_IN_BITS(W), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk_in(clk),
        .reset_in(rst),
        .bank_miss_request_flatted_in(miss_pkt),
        .bank_miss_request_valid_flatted_in(miss_valid),
        .bank_miss_request_critical_flatted_in(miss_crit),
        .bank_miss_request_ack_out(miss_ack),
        .bank_writeback_request_flatted_in(wb_pkt),
        .bank_writeback_request_valid_flatted_in(wb_valid),
        .bank_writeback_request_critical_flatted_in(wb_crit),
        .bank_writeback_request_ack_out(wb_ack),
        .mem_request_out(mem_pkt),
        .mem_request_valid_out(mem_valid),
        .mem_request_is_write_out(mem_wr),
        .mem_request_ack_in(mem_ack),
        .mem_response_in(resp_pkt),
        .mem_response_valid_in(resp_valid),
        .mem_response_ack_out(resp_ack),
        .bank_fetched_request_out(fetched_pkt),
        .bank_fetched_request_valid_flatted_out(fetched_valid),
        .bank_fetch_ack_flatted_in(fetch_ack),
        .outstanding_count_out(count),
        .unexpected_response_out(unexpected)
    );

    typedef struct packed { logic wr; logic [W-1:0] pkt; } req_t;
    req_t exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    // Every accepted memory request must match the oldest expected one.
    always @(negedge clk) begin
        req_t got, exp;
        if (!rst && mem_valid && mem_ack) begin
            got = {mem_wr, mem_pkt};
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL mem_req_extra got wr=%0b pkt=%h, none expected", mem_wr, mem_pkt);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) $display("FAIL mem_req got wr=%0b pkt=%h exp wr=%0b pkt=%h",
                                          got.wr, got.pkt, exp.wr, exp.pkt);
                else n_pass++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; miss_pkt = '0; wb_pkt = '0; miss_crit = '0; wb_crit = '0;
        miss_valid = '1; wb_valid = '1; mem_ack = 1'b1;
        resp_pkt = '0; resp_valid = 1'b1; fetch_ack = '1;
        tick(); tick(); #1;
        n_checks++; if (miss_ack !== 4'b0) $display("FAIL rst_miss_ack got=%b exp=0000", miss_ack); else n_pass++;
        n_checks++; if (wb_ack !== 4'b0) $display("FAIL rst_wb_ack got=%b exp=0000", wb_ack); else n_pass++;
        n_checks++; if ({mem_valid, mem_wr} !== 2'b00) $display("FAIL rst_mem_valid got=%b%b exp=00", mem_valid, mem_wr); else n_pass++;
        n_checks++; if (count !== 0) $display("FAIL rst_count got=%0d exp=0", count); else n_pass++;
        n_checks++; if ({unexpected, resp_ack, fetched_valid} !== 6'b0) $display("FAIL rst_resp got=%b%b%b exp=0", unexpected, resp_ack, fetched_valid); else n_pass++;
        miss_valid = '0; wb_valid = '0; resp_valid = 1'b0; fetch_ack = '0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_miss_burst();
        for (int i = 0; i < NB; i++) begin
            miss_valid[i] = 1'b1;
            miss_pkt[i*W +: W] = 32'h100 + 32'(i);
        end
        for (int i = 0; i < NB; i++) begin
            #1;
            n_checks++; if (miss_ack !== 4'(1 << i)) $display("FAIL burst_ack%0d got=%b exp=%b", i, miss_ack, 4'(1 << i)); else n_pass++;
            exp_q.push_back(req_t'({1'b0, 32'h100 + 32'(i)}));
            tick();
            miss_valid[i] = 1'b0;
        end
        n_checks++; if (count !== 4) $display("FAIL burst_count got=%0d exp=4", count); else n_pass++;
        miss_valid[0] = 1'b1; miss_pkt[0 +: W] = 32'h104;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_checks++; if (miss_ack !== 4'b0) $display("FAIL full_hold%0d got=%b exp=0000", c, miss_ack); else n_pass++;
            tick();
        end
        n_checks++; if (mem_valid !== 1'b0) $display("FAIL full_mem_valid got=%b exp=0", mem_valid); else n_pass++;
        resp_valid = 1'b1; fetch_ack = '1;
        for (int k = 0; k < 5; k++) begin
            resp_pkt = 32'hA0 + 32'(k);
            #1;
            n_checks++; if (fetched_valid !== 4'(1 << (k % NB))) $display("FAIL burst_route%0d got=%b exp=%b", k, fetched_valid, 4'(1 << (k % NB))); else n_pass++;
            if (k == 0) begin
                n_checks++; if (miss_ack !== 4'b0001) $display("FAIL pop_frees_slot got=%b exp=0001", miss_ack); else n_pass++;
                exp_q.push_back(req_t'({1'b0, 32'h104}));
            end
            tick();
            if (k == 0) begin
                miss_valid[0] = 1'b0;
                n_checks++; if (count !== 4) $display("FAIL push_pop_count got=%0d exp=4", count); else n_pass++;
            end
        end
        resp_valid = 1'b0; fetch_ack = '0;
        #1;
        n_checks++; if (count !== 0) $display("FAIL drain_count got=%0d exp=0", count); else n_pass++;
        tick();
    endtask

    task automatic test_wb_priority();
        wb_valid[2] = 1'b1; wb_pkt[2*W +: W] = 32'h200;
        miss_valid[1] = 1'b1; miss_pkt[1*W +: W] = 32'h201;
        #1;
        n_checks++; if ({wb_ack, miss_ack} !== 8'b0100_0000) $display("FAIL wb_first got wb=%b miss=%b exp wb=0100 miss=0000", wb_ack, miss_ack); else n_pass++;
        exp_q.push_back(req_t'({1'b1, 32'h200}));
        tick();
        wb_valid[2] = 1'b0;
        #1;
        n_checks++; if ({mem_valid, mem_wr, mem_pkt} !== {2'b11, 32'h200}) $display("FAIL wb_reg got v=%b wr=%b pkt=%h exp v=1 wr=1 pkt=200", mem_valid, mem_wr, mem_pkt); else n_pass++;
        n_checks++; if (miss_ack !== 4'b0010) $display("FAIL miss_second got=%b exp=0010", miss_ack); else n_pass++;
        exp_q.push_back(req_t'({1'b0, 32'h201}));
        tick();
        miss_valid[1] = 1'b0;
        #1;
        n_checks++; if (mem_wr !== 1'b0) $display("FAIL miss_is_write got=%b exp=0", mem_wr); else n_pass++;
        resp_valid = 1'b1; resp_pkt = 32'hC; fetch_ack = 4'b0010;
        #1;
        n_checks++; if (fetched_valid !== 4'b0010) $display("FAIL wb_drain_route got=%b exp=0010", fetched_valid); else n_pass++;
        tick();
        resp_valid = 1'b0; fetch_ack = '0;
        tick();
    endtask

    task automatic test_response_routing();
        miss_valid[3] = 1'b1; miss_pkt[3*W +: W] = 32'h303;
        #1;
        n_checks++; if (miss_ack !== 4'b1000) $display("FAIL route_issue3 got=%b exp=1000", miss_ack); else n_pass++;
        exp_q.push_back(req_t'({1'b0, 32'h303}));
        tick();
        miss_valid[3] = 1'b0; miss_valid[1] = 1'b1; miss_pkt[1*W +: W] = 32'h301;
        #1;
        n_checks++; if (miss_ack !== 4'b0010) $display("FAIL route_issue1 got=%b exp=0010", miss_ack); else n_pass++;
        exp_q.push_back(req_t'({1'b0, 32'h301}));
        tick();
        miss_valid[1] = 1'b0;
        resp_valid = 1'b1; resp_pkt = 32'hA; fetch_ack = '0;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_checks++; if ({fetched_valid, resp_ack, fetched_pkt} !== {4'b1000, 1'b0, 32'hA}) $display("FAIL route_stall%0d got v=%b ack=%b pkt=%h exp v=1000 ack=0 pkt=a", c, fetched_valid, resp_ack, fetched_pkt); else n_pass++;
            tick();
        end
        n_checks++; if (count !== 2) $display("FAIL route_stall_count got=%0d exp=2", count); else n_pass++;
        fetch_ack = 4'b1000;
        #1;
        n_checks++; if (resp_ack !== 1'b1) $display("FAIL route_ack3 got=%b exp=1", resp_ack); else n_pass++;
        tick();
        resp_pkt = 32'hB; fetch_ack = 4'b0010;
        #1;
        n_checks++; if ({fetched_valid, resp_ack, fetched_pkt} !== {4'b0010, 1'b1, 32'hB}) $display("FAIL route_b got v=%b ack=%b pkt=%h exp v=0010 ack=1 pkt=b", fetched_valid, resp_ack, fetched_pkt); else n_pass++;
        tick();
        resp_valid = 1'b0; fetch_ack = '0;
        #1;
        n_checks++; if (count !== 0) $display("FAIL route_count got=%0d exp=0", count); else n_pass++;
        tick();
    endtask

    task automatic test_stall();
        mem_ack = 1'b0;
        wb_valid[0] = 1'b1; wb_pkt[0 +: W] = 32'h400;
        #1;
        n_checks++; if (wb_ack !== 4'b0001) $display("FAIL stall_first got=%b exp=0001", wb_ack); else n_pass++;
        exp_q.push_back(req_t'({1'b1, 32'h400}));
        tick();
        wb_valid[0] = 1'b0; wb_valid[1] = 1'b1; wb_pkt[1*W +: W] = 32'h401;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_checks++; if ({mem_valid, mem_pkt, wb_ack} !== {1'b1, 32'h400, 4'b0}) $display("FAIL stall_hold%0d got v=%b pkt=%h ack=%b exp v=1 pkt=400 ack=0000", c, mem_valid, mem_pkt, wb_ack); else n_pass++;
            tick();
        end
        mem_ack = 1'b1;
        #1;
        n_checks++; if (wb_ack !== 4'b0010) $display("FAIL stall_resume got=%b exp=0010", wb_ack); else n_pass++;
        exp_q.push_back(req_t'({1'b1, 32'h401}));
        tick();
        wb_valid[1] = 1'b0;
        #1;
        n_checks++; if (mem_pkt !== 32'h401) $display("FAIL stall_next got=%h exp=401", mem_pkt); else n_pass++;
        tick();
    endtask

    task automatic test_unexpected();
        resp_valid = 1'b1; resp_pkt = 32'hDEAD; fetch_ack = '0;
        #1;
        n_checks++; if ({resp_ack, fetched_valid} !== 5'b1_0000) $display("FAIL unexp_ack got ack=%b v=%b exp ack=1 v=0000", resp_ack, fetched_valid); else n_pass++;
        tick();
        resp_valid = 1'b0;
        tick(); tick();
        n_checks++; if (unexpected !== 1'b1) $display("FAIL unexp_sticky got=%b exp=1", unexpected); else n_pass++;
        miss_valid[2] = 1'b1; miss_pkt[2*W +: W] = 32'h502;
        #1;
        n_checks++; if (miss_ack !== 4'b0100) $display("FAIL unexp_issue got=%b exp=0100", miss_ack); else n_pass++;
        exp_q.push_back(req_t'({1'b0, 32'h502}));
        tick();
        miss_valid[2] = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        n_checks++; if ({unexpected, count, mem_valid} !== 5'b0) $display("FAIL midrst got unexp=%b count=%0d v=%b exp 0", unexpected, count, mem_valid); else n_pass++;
        rst = 1'b0;
        tick();
        resp_valid = 1'b1; resp_pkt = 32'hBEEF; fetch_ack = 4'b0100;
        #1;
        n_checks++; if ({resp_ack, fetched_valid} !== 5'b1_0000) $display("FAIL midrst_resp got ack=%b v=%b exp ack=1 v=0000", resp_ack, fetched_valid); else n_pass++;
        tick();
        resp_valid = 1'b0; fetch_ack = '0;
        #1;
        n_checks++; if (unexpected !== 1'b1) $display("FAIL midrst_unexp got=%b exp=1", unexpected); else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_critical();
        wb_valid[0] = 1'b1; wb_crit[0] = 1'b0; wb_pkt[0 +: W] = 32'h600;
        miss_valid[2] = 1'b1; miss_crit[2] = 1'b1; miss_pkt[2*W +: W] = 32'h602;
        #1;
`ifdef UNIFIED_CACHE_MEM_CRITICAL_FIRST_EN
        n_checks++; if ({wb_ack, miss_ack} !== 8'b0000_0100) $display("FAIL crit_first got wb=%b miss=%b exp wb=0000 miss=0100", wb_ack, miss_ack); else n_pass++;
        exp_q.push_back(req_t'({1'b0, 32'h602}));
        tick();
        miss_valid[2] = 1'b0;
        #1;
        n_checks++; if (wb_ack !== 4'b0001) $display("FAIL crit_second got=%b exp=0001", wb_ack); else n_pass++;
        exp_q.push_back(req_t'({1'b1, 32'h600}));
        tick();
        wb_valid[0] = 1'b0;
`else
        n_checks++; if ({wb_ack, miss_ack} !== 8'b0001_0000) $display("FAIL crit_first got wb=%b miss=%b exp wb=0001 miss=0000", wb_ack, miss_ack); else n_pass++;
        exp_q.push_back(req_t'({1'b1, 32'h600}));
        tick();
        wb_valid[0] = 1'b0;
        #1;
        n_checks++; if (miss_ack !== 4'b0100) $display("FAIL crit_second got=%b exp=0100", miss_ack); else n_pass++;
        exp_q.push_back(req_t'({1'b0, 32'h602}));
        tick();
        miss_valid[2] = 1'b0;
`endif
        miss_crit = '0;
        resp_valid = 1'b1; resp_pkt = 32'hD; fetch_ack = 4'b0100;
        #1;
        n_checks++; if (fetched_valid !== 4'b0100) $display("FAIL crit_route got=%b exp=0100", fetched_valid); else n_pass++;
        tick();
        resp_valid = 1'b0; fetch_ack = '0;
        tick(); tick();
        n_checks++; if (exp_q.size() != 0) $display("FAIL scoreboard_left got=%0d exp=0 pending", exp_q.size()); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_miss_burst();
        test_wb_priority();
        test_response_routing();
        test_stall();
        test_unexpected();
        test_critical();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/unified_cache_mem_scheduler.md
Name: unified_cache_mem_scheduler

Overview:
- Shares one memory-side port between NUM_BANK unified cache banks.
- Arbitrates each bank's miss and writeback requests onto a single registered memory request channel.
- Tracks outstanding misses in an in-order bank-ID FIFO and routes each memory response back to the bank that issued the miss.
- Sits between the bank array and the memory/next-level interface.

Parameters:
NUM_BANK, 4, number of cache banks served (power of 2, >=2)
UNIFIED_CACHE_PACKET_WIDTH_IN_BITS, `UNIFIED_CACHE_PACKET_WIDTH_IN_BITS, packet width
MAX_OUTSTANDING, 4, maximum in-flight misses; depth of the bank-ID FIFO (power of 2)

Ports:
clk_in  input  1  clock
reset_in  input  1  synchronous active-high reset
bank_miss_request_flatted_in  input  NUM_BANK*W  miss packets; bank i at slice i
bank_miss_request_valid_flatted_in  input  NUM_BANK  miss valid per bank
bank_miss_request_critical_flatted_in  input  NUM_BANK  miss critical per bank
bank_miss_request_ack_out  output  NUM_BANK  one-hot miss capture ack
bank_writeback_request_flatted_in  input  NUM_BANK*W  writeback packets
bank_writeback_request_valid_flatted_in  input  NUM_BANK  writeback valid
bank_writeback_request_critical_flatted_in  input  NUM_BANK  writeback critical
bank_writeback_request_ack_out  output  NUM_BANK  one-hot writeback capture ack
mem_request_out  output  W  registered request packet
mem_request_valid_out  output  1  request valid
mem_request_is_write_out  output  1  1 = writeback, 0 = miss
mem_request_ack_in  input  1  memory accepts request
mem_response_in  input  W  fetched packet from memory
mem_response_valid_in  input  1  response valid
mem_response_ack_out  output  1  response consumed
bank_fetched_request_out  output  W  response packet, broadcast to all banks
bank_fetched_request_valid_flatted_out  output  NUM_BANK  one-hot response valid
bank_fetch_ack_flatted_in  input  NUM_BANK  per-bank response ack
outstanding_count_out  output  clog2(MAX_OUTSTANDING)+1  misses in flight
unexpected_response_out  output  1  sticky: response arrived with no miss in flight

Behaviour:
- Reset, synchronous and active-high:
  - Clears the output register; mem_request_valid_out=0 and mem_request_is_write_out=0.
  - Empties the FIFO; outstanding_count_out=0.
  - Sets both round-robin pointers to 0.
  - Clears unexpected_response_out.
  - All acks and valids are 0.
  - Reset mid-operation discards held and in-flight state. Responses arriving after reset count as unexpected.
- Output register is one entry, states EMPTY/FULL.
  - A load is allowed when the register is EMPTY, or FULL with mem_request_ack_in=1 in the same cycle. This gives back-to-back throughput of 1 per cycle.
  - FULL -> EMPTY on mem_request_ack_in with no new load.
  - Register contents stay stable while valid and not acked.
- Arbitration, combinational, in the load cycle:
  - Class order: writeback before miss.
  - Within a class: round-robin starting at that class's pointer.
  - After a grant, that class's pointer = granted bank + 1 mod NUM_BANK. The other pointer is unchanged.
- Miss gating:
  - Misses are ineligible when outstanding == MAX_OUTSTANDING.
  - Exception: a response pop in the same cycle frees a slot, so one miss may be granted.
- Ack timing:
  - The granted source's ack is a one-cycle pulse in the capture cycle.
  - Requesters hold valid and packet until acked. Never more than one ack bit is set per cycle.
- FIFO push: a miss capture pushes the bank ID. Writebacks push nothing.
- Response routing:
  - If mem_response_valid_in=1 and the FIFO is non-empty, assert valid for the head bank only.
  - mem_response_ack_out = bank_fetch_ack_flatted_in[head].
  - A handshake pops the FIFO.
  - Responses return in issue order.
- Unexpected response: if mem_response_valid_in=1 with the FIFO empty, ack it immediately, drop it, and set unexpected_response_out (sticky until reset).
- Count update: simultaneous push and pop leaves the count unchanged. FIFO pointers wrap modulo MAX_OUTSTANDING.

Optional Feature:
UNIFIED_CACHE_MEM_CRITICAL_FIRST_EN
- Defined: priority is critical writeback > critical miss > non-critical writeback > non-critical miss. Round-robin applies within each level, with one pointer per class.
- Undefined: critical inputs are ignored; plain writeback-before-miss order applies.

Test Plan:
- Banks 0-3 hold misses, outstanding=0, mem ack always 1 -> grants in order 0,1,2,3 on consecutive cycles; outstanding_count_out reaches 4; a fifth miss from bank 0 is held until a response pops.
- Bank 2 holds a writeback and bank 1 holds a miss in the same cycle -> writeback captured first with mem_request_is_write_out=1, miss captured the next cycle.
- Misses issued from banks 3 then 1, responses 0xA then 0xB -> 0xA is valid only to bank 3, then 0xB only to bank 1; withholding bank 3's ack stalls mem_response_ack_out.
- mem_request_ack_in low for 5 cycles -> mem_request_out unchanged, no new bank acks; capture resumes the cycle ack rises.
- Response with FIFO empty -> mem_response_ack_out=1 that cycle, no bank valid, unexpected_response_out=1 until reset_in.
- With the macro defined: non-critical writeback (bank 0) and critical miss (bank 2) -> miss from bank 2 granted first; without the macro -> writeback from bank 0 granted first.
